// File: rtl/draw_object_plotter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_object_plotter_pkg
// Description : Object-select codes, screen bounds and plotter state encodings
//               shared by the draw sequencer and the object plotter.
// Revision    : 1.0 - initial release
// ============================================================================
package draw_object_plotter_pkg;

    localparam logic [3:0] OBJ_PLAYER = 4'd0;
    localparam logic [3:0] OBJ_ENEMY1 = 4'd1;
    localparam logic [3:0] OBJ_ENEMY2 = 4'd2;
    localparam logic [3:0] OBJ_ENEMY3 = 4'd3;
    localparam logic [3:0] OBJ_ENEMY4 = 4'd4;
    localparam logic [3:0] OBJ_BULLET = 4'd5;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_LOAD = 2'd0;
    localparam logic [STATE_W-1:0] S_PLOT = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE = 2'd2;

    // Full-width sums are tested so wrapped low bits never sneak back on screen.
    function automatic logic on_screen(input logic [8:0] xs, input logic [7:0] ys);
        return (xs <= X_LAST) && (ys <= Y_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/draw_object_plotter_raster.sv
`default_nettype none
// ============================================================================
// Module      : rect_raster_counter
// Description : Column/row scan over a W x H rectangle with last-pixel flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_raster_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] W,
    input  logic [6:0] H,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);

    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic       w_row_end;

    assign w_row_end = (r_cx == W - 8'd1);
    assign last      = w_row_end && (r_cy == H - 7'd1);
    assign cx        = r_cx;
    assign cy        = r_cy;

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_row_end) begin
            r_cx <= '0;
            r_cy <= r_cy + 7'd1;
        end else begin
            r_cx <= r_cx + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/draw_object_plotter.sv
`default_nettype none
// ============================================================================
// Module      : draw_object_plotter
// Description : Latches one selected object and streams its pixels, one per
//               clock, to the 160x120 VGA adapter; pulses done when finished.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_object_plotter
    import draw_object_plotter_pkg::*;
#(
    parameter int         PLAYER_W   = 8,
    parameter int         PLAYER_H   = 8,
    parameter int         ENEMY_W    = 8,
    parameter int         ENEMY_H    = 8,
    parameter int         BULLET_W   = 2,
    parameter int         BULLET_H   = 4,
    parameter logic [2:0] PLAYER_COL = 3'b010,
    parameter logic [2:0] ENEMY_COL  = 3'b100,
    parameter logic [2:0] BULLET_COL = 3'b111
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  mainDrawSignal,
    input  logic [7:0]  playerX,
    input  logic [6:0]  playerY,
    input  logic [31:0] enemyX,
    input  logic [27:0] enemyY,
    input  logic [3:0]  enemyAlive,
    input  logic [7:0]  bulletX,
    input  logic [6:0]  bulletY,
    input  logic        bulletActive,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        done
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [7:0] r_base_x;
    logic [6:0] r_base_y;
    logic [7:0] r_w;
    logic [6:0] r_h;
    logic [2:0] r_col;

    logic [7:0] w_sel_x;
    logic [6:0] w_sel_y;
    logic [7:0] w_sel_w;
    logic [6:0] w_sel_h;
    logic [2:0] w_sel_col;
    logic       w_sel_valid;
    logic [1:0] w_enemy_idx;
    logic [4:0] w_ex_lsb;
    logic [4:0] w_ey_lsb;

    logic [7:0] w_cx;
    logic [6:0] w_cy;
    logic       w_last;
    logic       w_start;
    logic       w_row_end;
    logic [7:0] w_ncx;
    logic [6:0] w_ncy;
    logic [8:0] w_xs;
    logic [7:0] w_ys;

    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_done;
    logic [7:0] w_x_nxt;
    logic [6:0] w_y_nxt;
    logic [2:0] w_col_nxt;
    logic       w_plot_nxt;
    logic       w_done_nxt;

    // Enemy n occupies byte n-1 of enemyX and 7-bit field n-1 of enemyY.
    assign w_enemy_idx = mainDrawSignal[1:0] - 2'd1;
    assign w_ex_lsb    = {w_enemy_idx, 3'b000};
    assign w_ey_lsb    = {w_enemy_idx, 3'b000} - {3'b000, w_enemy_idx};

    always_comb begin
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_w     = '0;
        w_sel_h     = '0;
        w_sel_col   = '0;
        w_sel_valid = 1'b0;
        case (mainDrawSignal)
            OBJ_PLAYER: begin
                w_sel_x     = playerX;
                w_sel_y     = playerY;
                w_sel_w     = 8'(PLAYER_W);
                w_sel_h     = 7'(PLAYER_H);
                w_sel_col   = PLAYER_COL;
                w_sel_valid = 1'b1;
            end
            OBJ_ENEMY1, OBJ_ENEMY2, OBJ_ENEMY3, OBJ_ENEMY4: begin
                w_sel_x     = enemyX[w_ex_lsb +: 8];
                w_sel_y     = enemyY[w_ey_lsb +: 7];
                w_sel_w     = 8'(ENEMY_W);
                w_sel_h     = 7'(ENEMY_H);
                w_sel_col   = ENEMY_COL;
                w_sel_valid = enemyAlive[w_enemy_idx];
            end
            OBJ_BULLET: begin
                w_sel_x     = bulletX;
                w_sel_y     = bulletY;
                w_sel_w     = 8'(BULLET_W);
                w_sel_h     = 7'(BULLET_H);
                w_sel_col   = BULLET_COL;
                w_sel_valid = bulletActive;
            end
            default: ;
        endcase
    end

    assign w_start = (r_state == S_LOAD);

    rect_raster_counter u_raster (
        .clk    (clk),
        .resetn (resetn),
        .start  (w_start),
        .W      (r_w),
        .H      (r_h),
        .cx     (w_cx),
        .cy     (w_cy),
        .last   (w_last)
    );

    // Outputs are registered, so each edge loads the pixel the counter moves to.
    assign w_row_end = (w_cx == r_w - 8'd1);
    assign w_ncx     = w_row_end ? 8'd0 : w_cx + 8'd1;
    assign w_ncy     = w_row_end ? w_cy + 7'd1 : w_cy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  w_state_nxt = w_sel_valid ? S_PLOT : S_DONE;
            S_PLOT:  w_state_nxt = w_last ? S_DONE : S_PLOT;
            S_DONE:  w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_col_nxt  = r_colour;
        w_plot_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_xs       = '0;
        w_ys       = '0;
        case (r_state)
            S_LOAD: begin
                if (w_sel_valid) begin
                    w_xs       = {1'b0, w_sel_x};
                    w_ys       = {1'b0, w_sel_y};
                    w_x_nxt    = w_xs[7:0];
                    w_y_nxt    = w_ys[6:0];
                    w_col_nxt  = w_sel_col;
                    w_plot_nxt = on_screen(w_xs, w_ys);
                end else begin
                    w_done_nxt = 1'b1;
                end
            end
            S_PLOT: begin
                if (w_last) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_xs       = {1'b0, r_base_x} + {1'b0, w_ncx};
                    w_ys       = {1'b0, r_base_y} + {1'b0, w_ncy};
                    w_x_nxt    = w_xs[7:0];
                    w_y_nxt    = w_ys[6:0];
                    w_col_nxt  = r_col;
                    w_plot_nxt = on_screen(w_xs, w_ys);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_base_x <= '0;
            r_base_y <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_col    <= '0;
        end else if (r_state == S_LOAD) begin
            r_base_x <= w_sel_x;
            r_base_y <= w_sel_y;
            r_w      <= w_sel_w;
            r_h      <= w_sel_h;
            r_col    <= w_sel_col;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_col_nxt;
            r_plot   <= w_plot_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_draw_object_plotter.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_object_plotter
// Description : Self-checking bench for draw_object_plotter with a raster
//               reference model, vector table, directed and random sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_draw_object_plotter;

    localparam int PW = 8, PH = 8, EW = 8, EH = 8, BW = 2, BH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  mainDrawSignal = '0;
    logic [7:0]  playerX = '0;
    logic [6:0]  playerY = '0;
    logic [31:0] enemyX = '0;
    logic [27:0] enemyY = '0;
    logic [3:0]  enemyAlive = '0;
    logic [7:0]  bulletX = '0;
    logic [6:0]  bulletY = '0;
    logic        bulletActive = 1'b0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    draw_object_plotter dut (
        .clk            (clk),
        .resetn         (resetn),
        .mainDrawSignal (mainDrawSignal),
        .playerX        (playerX),
        .playerY        (playerY),
        .enemyX         (enemyX),
        .enemyY         (enemyY),
        .enemyAlive     (enemyAlive),
        .bulletX        (bulletX),
        .bulletY        (bulletY),
        .bulletActive   (bulletActive),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .done           (done)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       plot;
    } pix_t;

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  px;
        logic [6:0]  py;
        logic [31:0] ex;
        logic [27:0] ey;
        logic [3:0]  alive;
        logic [7:0]  bx;
        logic [6:0]  by;
        logic        bact;
        int          exp_len;
        int          exp_plots;
    } vec_t;

    pix_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Pixel list for the currently selected object, straight from the object rules.
    task automatic build_model(output int plots);
        int bx, by, w, h, n;
        logic [2:0] col;
        bit active;
        logic [31:0] ex_sh;
        logic [27:0] ey_sh;
        pix_t p;
        exp_q.delete();
        plots = 0;
        bx = 0; by = 0; w = 0; h = 0; col = 3'b000; active = 0;
        n = int'(mainDrawSignal);
        if (n == 0) begin
            bx = int'(playerX); by = int'(playerY); w = PW; h = PH; col = 3'b010; active = 1;
        end else if (n >= 1 && n <= 4) begin
            ex_sh = enemyX >> (8 * (n - 1));
            ey_sh = enemyY >> (7 * (n - 1));
            bx = int'(ex_sh[7:0]); by = int'(ey_sh[6:0]);
            w = EW; h = EH; col = 3'b100; active = enemyAlive[n - 1];
        end else if (n == 5) begin
            bx = int'(bulletX); by = int'(bulletY); w = BW; h = BH; col = 3'b111; active = bulletActive;
        end
        if (active) begin
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    p.x    = 8'((bx + c) % 256);
                    p.y    = 7'((by + r) % 128);
                    p.col  = col;
                    p.plot = ((bx + c) < 160) && ((by + r) < 120);
                    if (p.plot) plots++;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Checks one object from its first pixel sample through the following load cycle.
    task automatic run_stream(input string tag, input int chg_at, input logic [7:0] new_px,
                              input logic [3:0] next_sel, output int cycles, output int plots);
        pix_t p;
        cycles = 0;
        plots  = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            cycles++;
            if (i == chg_at) playerX = new_px;
            p = exp_q[i];
            check({tag, " pixel"}, 32'({x, y, colour, plot, done}), 32'({p.x, p.y, p.col, p.plot, 1'b0}));
            if (plot) plots++;
        end
        @(negedge clk);
        cycles++;
        check({tag, " done"}, 32'({plot, done}), 32'b01);
        mainDrawSignal = next_sel;
        @(negedge clk);
        cycles++;
        check({tag, " load"}, 32'({plot, done}), 32'b00);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset state", 32'({x, y, colour, plot, done}), 32'd0);
    endtask

    task automatic randomize_positions();
        playerX = 8'($urandom_range(0, 255));
        playerY = 7'($urandom_range(0, 127));
        enemyX  = $urandom();
        enemyY  = 28'($urandom());
        bulletX = 8'($urandom_range(0, 255));
        bulletY = 7'($urandom_range(0, 127));
        enemyAlive   = 4'($urandom());
        bulletActive = 1'($urandom());
    endtask

    vec_t vecs[10];
    logic [3:0] sel_seq[25];

    initial begin
        int mp, cyc, pl, total;

        vecs[0] = '{4'd0,  8'd10,  7'd20,  32'd0, 28'd0, 4'b0000, 8'd0,   7'd0,   1'b0, 64, 64};
        vecs[1] = '{4'd2,  8'd0,   7'd0,   32'd0, 28'd0, 4'b1101, 8'd0,   7'd0,   1'b0, 0,  0};
        vecs[2] = '{4'd9,  8'd0,   7'd0,   32'd0, 28'd0, 4'b1111, 8'd0,   7'd0,   1'b1, 0,  0};
        vecs[3] = '{4'd5,  8'd0,   7'd0,   32'd0, 28'd0, 4'b0000, 8'd159, 7'd118, 1'b1, 8,  2};
        vecs[4] = '{4'd5,  8'd0,   7'd0,   32'd0, 28'd0, 4'b1111, 8'd20,  7'd20,  1'b0, 0,  0};
        vecs[5] = '{4'd3,  8'd0,   7'd0,   {8'd0, 8'd155, 8'd0, 8'd0}, {7'd0, 7'd115, 7'd0, 7'd0},
                    4'b0100, 8'd0, 7'd0, 1'b0, 64, 25};
        vecs[6] = '{4'd4,  8'd0,   7'd0,   {8'd0, 8'd1, 8'd2, 8'd3}, {7'd0, 7'd1, 7'd2, 7'd3},
                    4'b1000, 8'd0, 7'd0, 1'b0, 64, 64};
        vecs[7] = '{4'd1,  8'd0,   7'd0,   {8'd9, 8'd9, 8'd9, 8'd250}, {7'd9, 7'd9, 7'd9, 7'd125},
                    4'b0001, 8'd0, 7'd0, 1'b0, 64, 0};
        vecs[8] = '{4'd0,  8'd152, 7'd112, 32'd0, 28'd0, 4'b0000, 8'd0,   7'd0,   1'b0, 64, 64};
        vecs[9] = '{4'd15, 8'd0,   7'd0,   32'd0, 28'd0, 4'b1111, 8'd0,   7'd0,   1'b1, 0,  0};

        // Vector table: each entry drawn once from reset.
        for (int v = 0; v < 10; v++) begin
            mainDrawSignal = vecs[v].sel;
            playerX = vecs[v].px;   playerY = vecs[v].py;
            enemyX  = vecs[v].ex;   enemyY  = vecs[v].ey;
            enemyAlive = vecs[v].alive;
            bulletX = vecs[v].bx;   bulletY = vecs[v].by;
            bulletActive = vecs[v].bact;
            do_reset();
            build_model(mp);
            resetn = 1'b1;
            run_stream($sformatf("vec%0d", v), -1, 8'd0, vecs[v].sel, cyc, pl);
            check($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_len + 2));
            check($sformatf("vec%0d plots", v), 32'(pl), 32'(vecs[v].exp_plots));
        end

        // Reset during pixel 30 of enemy 1, then a full restart.
        mainDrawSignal = 4'd1;
        enemyAlive = 4'b0001;
        enemyX = {8'd0, 8'd0, 8'd0, 8'd40};
        enemyY = {7'd0, 7'd0, 7'd0, 7'd50};
        do_reset();
        build_model(mp);
        resetn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("mid-reset pre pixel", 32'({x, y, colour, plot, done}),
                  32'({exp_q[i].x, exp_q[i].y, exp_q[i].col, exp_q[i].plot, 1'b0}));
        end
        resetn = 1'b0;
        @(negedge clk);
        check("mid-reset outputs", 32'({x, y, colour, plot, done}), 32'd0);
        resetn = 1'b1;
        run_stream("mid-reset restart", -1, 8'd0, 4'd1, cyc, pl);
        check("mid-reset restart plots", 32'(pl), 32'd64);

        // Player X changed mid-draw: current pass keeps old X, next pass uses new X.
        mainDrawSignal = 4'd0;
        playerX = 8'd30;
        playerY = 7'd40;
        do_reset();
        build_model(mp);
        resetn = 1'b1;
        run_stream("xchg pass1", 10, 8'd90, 4'd0, cyc, pl);
        build_model(mp);
        check("xchg pass2 model x", 32'(exp_q[0].x), 32'd90);
        run_stream("xchg pass2", -1, 8'd0, 4'd0, cyc, pl);

        // Sequencer loop, all objects active: two full frames of 340 cycles.
        randomize_positions();
        playerX = 8'd5;  enemyX = {8'd100, 8'd70, 8'd40, 8'd10};
        bulletX = 8'd80; enemyY = {7'd30, 7'd20, 7'd10, 7'd0};
        enemyAlive = 4'b1111;
        bulletActive = 1'b1;
        mainDrawSignal = 4'd0;
        do_reset();
        resetn = 1'b1;
        for (int f = 0; f < 2; f++) begin
            total = 0;
            for (int s = 0; s < 6; s++) begin
                build_model(mp);
                run_stream($sformatf("seq obj%0d", s), -1, 8'd0, (s == 5) ? 4'd0 : 4'(s + 1), cyc, pl);
                total += cyc;
            end
            check($sformatf("frame%0d cycles", f), 32'(total), 32'd340);
        end

        // Randomized objects chained back to back through the done handshake.
        for (int i = 0; i < 25; i++) sel_seq[i] = 4'($urandom_range(0, 7));
        randomize_positions();
        mainDrawSignal = sel_seq[0];
        do_reset();
        resetn = 1'b1;
        for (int i = 0; i < 24; i++) begin
            build_model(mp);
            run_stream($sformatf("rand%0d", i), -1, 8'd0, sel_seq[i + 1], cyc, pl);
            check($sformatf("rand%0d plots", i), 32'(pl), 32'(mp));
            randomize_positions();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_object_plotter.md
# draw_object_plotter

Display-side counterpart to the draw-sequencing FSM. Accepts the 4-bit object select (`mainDrawSignal`), latches that object's position, size and colour, then streams one pixel per clock (`x`, `y`, `colour`, `plot`) to the 160×120 VGA adapter. Asserts a one-cycle `done` when the object is finished so the sequencer advances to the next object.

## Interface
Parameters:
- `PLAYER_W`, 8: player sprite width in pixels.
- `PLAYER_H`, 8: player sprite height.
- `ENEMY_W`, 8: enemy sprite width.
- `ENEMY_H`, 8: enemy sprite height.
- `BULLET_W`, 2: bullet width.
- `BULLET_H`, 4: bullet height.
- `PLAYER_COL`, 3'b010: player colour.
- `ENEMY_COL`, 3'b100: enemy colour.
- `BULLET_COL`, 3'b111: bullet colour.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: synchronous reset, active-low.
- `mainDrawSignal` in 4: object select. 0 is player, 1–4 are enemies 1–4, 5 is bullet, 6–15 are invalid.
- `playerX` in 8 / `playerY` in 7: player top-left corner.
- `enemyX` in 32: packed X coordinates; enemy *n* is at [8n-1:8n-8].
- `enemyY` in 28: packed Y coordinates; enemy *n* is at [7n-1:7n-7].
- `enemyAlive` in 4: bit *n-1* is set when enemy *n* is alive.
- `bulletX` in 8 / `bulletY` in 7 / `bulletActive` in 1: bullet position and active flag.
- `x` out 8 / `y` out 7: pixel coordinate sent to the VGA adapter.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel write enable.
- `done` out 1: one-cycle pulse when the current object is finished.

## Operation
States:
- **S_LOAD**
  - Sample `mainDrawSignal`.
  - Latch the selected object's base X/Y, width W, height H and colour.
  - Clear the column counter `cx` and row counter `cy`.
  - Go to S_PLOT if the object is valid and active. Otherwise go to S_DONE (skip).
  - Inactive means enemy not alive, bullet not active, or select ≥6. The player is always active.
- **S_PLOT**
  - Each cycle, drive `x` = base X + `cx`, `y` = base Y + `cy`, `colour` = latched colour.
  - `plot`=1 unless the pixel is clipped.
  - Counter update: `cx` increments. When `cx`=W-1, `cx` goes to 0 and `cy` increments.
  - On the cycle with `cx`=W-1 and `cy`=H-1, go to S_DONE.
- **S_DONE**: `done`=1, `plot`=0, then go to S_LOAD.

Arithmetic and edge cases:
- Sums are computed 9 bits wide (X) and 8 bits wide (Y).
- Clipping: if the X sum >159 or the Y sum >119, that pixel has `plot`=0. It still consumes its cycle, and the low bits are still driven on `x`/`y`.
- Position inputs are sampled only in S_LOAD. Changes during S_PLOT do not affect the object being drawn, so there is no tearing.
- Select changes mid-object are ignored until the next S_LOAD.
- Reset (resetn low at any edge, including mid-object):
  - Go to S_LOAD.
  - `x`=0, `y`=0, `colour`=0, `plot`=0, `done`=0.
  - `cx`, `cy` and all latched fields are cleared.
- Outputs are registered. `plot`=0 in S_LOAD and S_DONE.

## Timing
- Active W×H object: 1 load cycle + W·H plot cycles + 1 done cycle, i.e. W·H+2 cycles from S_LOAD to the next S_LOAD.
- Skipped object: 2 cycles (LOAD, DONE).
- Handshake:
  - `done` is high for exactly one cycle.
  - The sequencer changes `mainDrawSignal` on the edge that ends the `done` cycle.
  - This block samples the new select in the following S_LOAD.
- Pixel output latency: first `plot` appears the cycle after S_LOAD, i.e. 1 cycle after select sampling.
- Full frame with all objects active and default sizes: 5·66 + 10 = 340 cycles.

## Structure
- Shared package/header holds:
  - Object-select constants `OBJ_PLAYER`=0 … `OBJ_BULLET`=5, used by both the sequencer and this block.
  - Screen bounds 160/120.
  - State encodings.
- Sub-module `rect_raster_counter`:
  - Inputs: `clk`, `resetn`, `start`, `W`, `H`.
  - Outputs: `cx`, `cy`, `last`.
  - Owns the column/row counting and last-pixel detection.
  - The top level owns the FSM, object mux, addition and clipping.

## Test plan
- **Player draw:** reset, select=0, playerX=10, playerY=20. Required: 64 `plot` pulses covering x 10–17, y 20–27 in raster order, colour 3'b010, then exactly one `done` on cycle 66.
- **Skip path:** select=2, enemyAlive=4'b1101. Required: no `plot`, `done` on the 2nd cycle. Repeat with select=9: same result.
- **Clipping:** bullet at X=159, Y=118, bulletActive=1. Required: 8 plot cycles, only (159,118) and (159,119) have `plot`=1, then `done`.
- **Sequencer loop:** connect to the sequencer, all objects active. Required: `done` count = 6 per 340 cycles, select steps 0→5→0, and no pixel is driven with a stale select.
- **Reset mid-draw:** drop resetn during pixel 30 of enemy 1. Required: next cycle `plot`=0, `done`=0, `x`=`y`=0. After release, the draw restarts from pixel 0 of the current select.
- **Position change mid-draw:** change playerX during S_PLOT. Required: the current object keeps the old X, and the next pass uses the new X.
